// File: rtl/pi_mul_pkg.sv
// Shared types and tables for the pi_mul scheduler: state encoding, operand widths,
// per-step shift amounts and the nibble-select table used to sequence partial products.
package pi_mul_pkg;

    localparam int OP_W   = 8;
    localparam int NIB_W  = 4;
    localparam int PROD_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef logic [1:0] step_t;

    // Steps: lo*lo, hi*lo, lo*hi, hi*hi
    localparam logic [3:0] STEP_SHIFT [4] = '{4'd0, 4'd4, 4'd4, 4'd8};

    // Per step: bit0 selects the upper nibble of A, bit1 the upper nibble of B
    localparam logic [1:0] NIB_SEL [4] = '{2'b00, 2'b01, 2'b10, 2'b11};

    function automatic logic [NIB_W-1:0] nib(input logic [OP_W-1:0] v, input logic hi);
        return hi ? v[7:4] : v[3:0];
    endfunction

    function automatic logic step_active(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b,
                                         input step_t s);
        return (nib(a, NIB_SEL[s][0]) != '0) && (nib(b, NIB_SEL[s][1]) != '0);
    endfunction

    // Returns {found, step} of the first contributing step at index >= from
    function automatic logic [2:0] next_active(input logic [OP_W-1:0] a,
                                               input logic [OP_W-1:0] b,
                                               input logic [2:0] from);
        for (int s = 0; s < 4; s++) begin
            if (3'(s) >= from && step_active(a, b, step_t'(s)))
                return {1'b1, 2'(s)};
        end
        return 3'b000;
    endfunction

endpackage

// File: rtl/pi_mul4x4.sv
// Combinational 4x4 -> 8 unsigned nibble multiplier shared by all requesters.
module pi_mul4x4
    import pi_mul_pkg::*;
(
    input  logic [NIB_W-1:0]   a,
    input  logic [NIB_W-1:0]   b,
    output logic [2*NIB_W-1:0] p
);

    assign p = a * b;

endmodule

// File: rtl/pi_mul_scheduler.sv
// Round-robin scheduler time-sharing one 4x4 multiplier to form 8x8 products.
// Build option PI_MUL_EARLY_EXIT_EN skips partial-product steps with a zero nibble.
module pi_mul_scheduler
    import pi_mul_pkg::*;
#(
    parameter  int NREQ = 2,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [8*NREQ-1:0]    req_a,
    input  logic [8*NREQ-1:0]    req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [PROD_W-1:0]    rsp_prod,
    output logic                 busy
);

    state_t              state_reg;
    logic [IDW-1:0]      rr_ptr_reg;
    logic [PROD_W-1:0]   acc_reg;
    step_t               step_reg;
    logic [OP_W-1:0]     a_reg;
    logic [OP_W-1:0]     b_reg;
    logic [IDW-1:0]      id_reg;
    logic                rsp_valid_reg;
    logic [IDW-1:0]      rsp_id_reg;
    logic [PROD_W-1:0]   rsp_prod_reg;
    logic                busy_reg;

    logic [OP_W-1:0]     op_a [NREQ];
    logic [OP_W-1:0]     op_b [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign op_a[gi] = req_a[8*gi +: 8];
        assign op_b[gi] = req_b[8*gi +: 8];
    end

    logic                grant_found;
    logic [IDW-1:0]      grant_id;
    logic                accept;

    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!grant_found && req_valid[(int'(rr_ptr_reg) + k) % NREQ]) begin
                grant_found = 1'b1;
                grant_id    = IDW'((int'(rr_ptr_reg) + k) % NREQ);
            end
        end
    end

    // Grant is suppressed while reset is held so no requester sees a spurious handshake
    assign accept    = rst_n && (state_reg == ST_IDLE) && grant_found;
    assign req_ready = accept ? (NREQ'(1) << grant_id) : '0;

    logic [NIB_W-1:0]    mul_a;
    logic [NIB_W-1:0]    mul_b;
    logic [2*NIB_W-1:0]  mul_p;
    logic [PROD_W-1:0]   acc_next;

    assign mul_a    = nib(a_reg, NIB_SEL[step_reg][0]);
    assign mul_b    = nib(b_reg, NIB_SEL[step_reg][1]);
    assign acc_next = acc_reg + (PROD_W'(mul_p) << STEP_SHIFT[step_reg]);

    pi_mul4x4 u_mul (
        .a (mul_a),
        .b (mul_b),
        .p (mul_p)
    );

`ifdef PI_MUL_EARLY_EXIT_EN
    logic [2:0] first_step;
    logic [2:0] next_step;
    assign first_step = next_active(op_a[grant_id], op_b[grant_id], 3'd0);
    assign next_step  = next_active(a_reg, b_reg, {1'b0, step_reg} + 3'd1);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            rr_ptr_reg    <= '0;
            acc_reg       <= '0;
            step_reg      <= '0;
            a_reg         <= '0;
            b_reg         <= '0;
            id_reg        <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_id_reg    <= '0;
            rsp_prod_reg  <= '0;
            busy_reg      <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        a_reg      <= op_a[grant_id];
                        b_reg      <= op_b[grant_id];
                        id_reg     <= grant_id;
                        acc_reg    <= '0;
                        busy_reg   <= 1'b1;
                        rr_ptr_reg <= (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
`ifdef PI_MUL_EARLY_EXIT_EN
                        if (first_step[2]) begin
                            step_reg  <= first_step[1:0];
                            state_reg <= ST_CALC;
                        end else begin
                            step_reg      <= '0;
                            state_reg     <= ST_RESP;
                            rsp_valid_reg <= 1'b1;
                            rsp_prod_reg  <= '0;
                            rsp_id_reg    <= grant_id;
                        end
`else
                        step_reg  <= '0;
                        state_reg <= ST_CALC;
`endif
                    end
                end
                ST_CALC: begin
                    acc_reg <= acc_next;
`ifdef PI_MUL_EARLY_EXIT_EN
                    if (next_step[2]) begin
                        step_reg <= next_step[1:0];
                    end else begin
`else
                    if (step_reg != 2'd3) begin
                        step_reg <= step_reg + 2'd1;
                    end else begin
`endif
                        state_reg     <= ST_RESP;
                        rsp_valid_reg <= 1'b1;
                        rsp_prod_reg  <= acc_next;
                        rsp_id_reg    <= id_reg;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state_reg     <= ST_IDLE;
                        rsp_valid_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign rsp_valid = rsp_valid_reg;
    assign rsp_id    = rsp_id_reg;
    assign rsp_prod  = rsp_prod_reg;
    assign busy      = busy_reg;

endmodule

// File: tb/tb_pi_mul_scheduler.sv
// Randomized self-checking bench for pi_mul_scheduler against a product/latency/round-robin model.
module tb_pi_mul_scheduler;

    localparam int NREQ = 2;
    localparam int IDW  = 1;
`ifdef PI_MUL_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NREQ-1:0]     req_valid;
    logic [8*NREQ-1:0]   req_a;
    logic [8*NREQ-1:0]   req_b;
    logic [NREQ-1:0]     req_ready;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [IDW-1:0]      rsp_id;
    logic [15:0]         rsp_prod;
    logic                busy;

    always #5 clk = ~clk;

    pi_mul_scheduler #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_prod  (rsp_prod),
        .busy      (busy)
    );

    int n_cmp = 0;
    int n_err = 0;
    int ptr_m = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Early exit: one cycle per contributing nibble pair plus the RESP entry cycle
    function automatic int exp_lat(input logic [7:0] a, input logic [7:0] b);
        int n = 0;
        if (a[3:0] != 0 && b[3:0] != 0) n++;
        if (a[7:4] != 0 && b[3:0] != 0) n++;
        if (a[3:0] != 0 && b[7:4] != 0) n++;
        if (a[7:4] != 0 && b[7:4] != 0) n++;
        return EARLY ? n + 1 : 5;
    endfunction

    // Called at a negedge; returns at the negedge after the response handshake.
    task automatic txn(input logic [NREQ-1:0] vmask, input int hold, input bit scramble);
        int g;
        int k;
        int lat;
        logic [7:0]  ea;
        logic [7:0]  eb;
        logic [15:0] ep;
        req_valid = vmask;
        rsp_ready = 1'b0;
        #1;
        g = -1;
        for (int j = 0; j < NREQ; j++) begin
            int idx = (ptr_m + j) % NREQ;
            if (g < 0 && vmask[idx]) g = idx;
        end
        check("grant", 32'(req_ready), 32'(1) << g);
        ea  = req_a[8*g +: 8];
        eb  = req_b[8*g +: 8];
        ep  = 16'(ea) * 16'(eb);
        lat = exp_lat(ea, eb);
        @(posedge clk);
        ptr_m = (g + 1) % NREQ;
        @(negedge clk);
        k = 1;
        if (scramble) begin
            req_valid = NREQ'($urandom);
            req_a     = 16'($urandom);
            req_b     = 16'($urandom);
        end
        while (!rsp_valid && k < 20) begin
            check("busy_calc", 32'(busy), 32'd1);
            @(negedge clk);
            k++;
        end
        check("latency", 32'(k), 32'(lat));
        check("prod", 32'(rsp_prod), 32'(ep));
        check("id", 32'(rsp_id), 32'(g));
        $display("txn id=%0d a=%02h b=%02h prod=%04h lat=%0d hold=%0d", g, ea, eb, rsp_prod, k, hold);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_valid", 32'(rsp_valid), 32'd1);
            check("hold_prod", 32'(rsp_prod), 32'(ep));
            check("hold_id", 32'(rsp_id), 32'(g));
            check("hold_ready", 32'(req_ready), 32'd0);
            check("hold_busy", 32'(busy), 32'd1);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        if (scramble) req_valid = '0;
        @(negedge clk);
        check("rsp_done", 32'(rsp_valid), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '1;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_valid", 32'(rsp_valid), 32'd0);
        check("rst_prod", 32'(rsp_prod), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_id", 32'(rsp_id), 32'd0);
        rst_n     = 1'b1;
        req_valid = '0;
        @(negedge clk);

        // single FF*FF request from requester 0
        req_a = 16'h00FF;
        req_b = 16'h00FF;
        txn(2'b01, 0, 1'b0);

        // reset mid-operation: no response, pointer back to 0
        req_valid = 2'b01;
        #1;
        check("midrst_grant", 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = 2'b11;
        #1;
        check("midrst_valid", 32'(rsp_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("midrst_norsp", 32'(rsp_valid), 32'd0);
        end
        rst_n = 1'b1;
        ptr_m = 0;

        // fairness: both valid continuously, grants alternate starting at 0
        req_a = {8'h12, 8'h03};
        req_b = {8'h34, 8'h05};
        for (int i = 0; i < 4; i++) begin
            txn(2'b11, 0, 1'b0);
            check("fair_prod", 32'(rsp_prod), (i % 2 == 0) ? 32'h0000000F : 32'h000003A8);
        end

        // backpressure for 10 cycles
        req_a = {8'h00, 8'hA7};
        req_b = {8'h00, 8'h5C};
        txn(2'b01, 10, 1'b0);

        // early-exit operand patterns
        req_a = {8'h00, 8'h03};
        req_b = {8'h00, 8'h05};
        txn(2'b01, 0, 1'b0);
        req_a = {8'h00, 8'h00};
        req_b = {8'h00, 8'h7F};
        txn(2'b01, 0, 1'b0);
        req_a = {8'h00, 8'h30};
        req_b = {8'h00, 8'h50};
        txn(2'b01, 1, 1'b0);

        // randomized traffic
        for (int i = 0; i < 40; i++) begin
            logic [NREQ-1:0] vm;
            vm = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            req_a = 16'($urandom);
            req_b = 16'($urandom);
            if ($urandom_range(0, 3) == 0) req_a[7:4] = 4'h0;
            if ($urandom_range(0, 3) == 0) req_b[11:8] = 4'h0;
            txn(vm, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
